mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Sequences all memory traffic of the pipelined MIPS core onto a single SRAM-like bus port. It shares that port between instruction fetch and the MEM-stage load/store path, one transaction outstanding at a time. It forwards the byte-lane write strobes produced by store byte-enable selection. A store whose strobes are all zero, because an exception suppressed it, is retired locally without a bus cycle.

## Interface
- No parameters.
- clk  in  1  system clock; everything samples on rising edge
- rst  in  1  synchronous, active-high reset
- inst_req  in  1  fetch request; held until inst_addr_ok
- inst_addr  in  32  fetch address (word aligned)
- inst_addr_ok  out  1  one-cycle pulse: fetch request accepted
- inst_data_ok  out  1  one-cycle pulse: inst_rdata valid
- inst_rdata  out  32  fetched word
- data_req  in  1  MEM-stage request; held until data_addr_ok
- data_wr  in  1  1 = store, 0 = load
- data_size  in  2  0 byte, 1 half, 2 word
- data_addr  in  32  byte address
- data_wdata  in  32  store data, already lane-aligned
- data_wstrb  in  4  byte-lane write enables (memwriteM)
- data_addr_ok  out  1  one-cycle pulse: data request accepted
- data_data_ok  out  1  one-cycle pulse: load data valid or store complete
- data_rdata  out  32  load word
- bus_req, bus_wr  out  1 each  bus request / write
- bus_size  out  2  transfer size
- bus_addr, bus_wdata  out  32 each  address / write data
- bus_wstrb  out  4  write strobes
- bus_addr_ok, bus_data_ok  in  1 each  bus handshakes
- bus_rdata  in  32  bus read data
- busy  out  1  state != IDLE

## Operation
- States: IDLE, ADDR, DATA, LOCAL. One owner register: 0 = inst, 1 = data. One last_grant register.
- **IDLE grant:**
  - If only one of data_req / inst_req is high, that requester wins.
  - If both are high, data wins unless last_grant == data, in which case inst wins. This is round-robin and prevents fetch starvation.
  - In the grant cycle, the winner's addr_ok pulses. owner, last_grant and the request fields are latched into registers.
  - For inst, the latched fields are: wr = 0, size = 2, wstrb = 0, wdata = 0.
- **Next state after a grant:**
  - Data grant with data_wr = 1 and data_wstrb == 0: go to LOCAL.
  - Any other grant: go to ADDR.
- **ADDR:** bus_req = 1 and the bus_* outputs carry the latched fields. On bus_addr_ok, go to DATA.
- **DATA:** bus_req = 0. On bus_data_ok:
  - Owner's data_ok = 1 in that same cycle (combinational).
  - Owner's rdata = bus_rdata.
  - Next state is IDLE.
- **LOCAL:** data_data_ok = 1 for one cycle with no bus activity. Next state is IDLE.
- No new grant is made in the cycle of a data_ok. The earliest next grant is the following IDLE cycle.
- Loads forward bus_rdata unmodified. Sign extension and lane selection are done downstream.
- Ignored inputs:
  - bus_addr_ok outside ADDR.
  - bus_data_ok outside DATA, including a late response arriving after reset.
  - Requests in non-IDLE states. They are not acknowledged.
- **Reset:**
  - State becomes IDLE. owner = 0, last_grant = 0 (inst).
  - All bus_* outputs are 0. All *_ok outputs are 0. Both rdata outputs are 0. busy = 0.
  - Reset mid-transaction drops bus_req immediately and never acknowledges the aborted owner.

## Timing
- bus_* outputs are driven from registers only. There is no combinational path from any request input to the bus.
- addr_ok outputs are combinational from IDLE and the req inputs.
- Minimum load/fetch latency: grant in cycle T, bus_req in cycle T+1.
  - If bus_addr_ok arrives in T+1 and bus_data_ok in T+2, the owner sees data_ok in T+2.
  - The next grant is possible in T+3.
- Suppressed store: grant in cycle T, data_data_ok in T+1, next grant in T+2.
- bus_req stays high through any number of ADDR wait cycles, with bus_addr/bus_wdata/bus_wstrb stable.
- The arbiter waits indefinitely in DATA. There is no timeout.

## Test plan
- **Fetch only:** inst_req = 1, inst_addr = 0xBFC00000; bus answers addr_ok in T+1 and data_ok in T+2 with rdata 0x3C1D0000.
  - Required: inst_addr_ok in T; bus_req in T+1 with bus_wr = 0, bus_size = 2; inst_data_ok and inst_rdata = 0x3C1D0000 in T+2; busy low in T+3.
- **SB store:** data_wr = 1, size 0, addr 0x80001003, wstrb 4'b1000, wdata 0xAB000000.
  - Required: bus carries exactly these values for every ADDR cycle, including 3 addr_ok wait cycles; data_data_ok on bus_data_ok.
- **Simultaneous requests, held for three transactions:** inst_req and data_req both high.
  - Required: grant order data, inst, data.
- **Suppressed store:** data_wr = 1, wstrb 0.
  - Required: data_addr_ok in T, data_data_ok in T+1, bus_req never asserted.
- **Reset in DATA:** assert rst while in DATA, then deliver bus_data_ok one cycle after rst deasserts.
  - Required: all outputs 0; no *_data_ok pulse; a subsequent inst_req is granted normally.
- **Stray handshakes:** pulse bus_addr_ok and bus_data_ok while in IDLE with no requests.
  - Required: state stays IDLE; no *_ok pulses.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one SRAM-like bus port between instruction fetch and
// the MEM-stage load/store path. Only one transaction is outstanding at a time.
//
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   inst_req/inst_addr         fetch request (held until inst_addr_ok)
//   inst_addr_ok/inst_data_ok  fetch accept pulse / fetch data valid pulse
//   inst_rdata                 fetched word (valid with inst_data_ok)
//   data_req/wr/size/addr      MEM-stage request (held until data_addr_ok)
//   data_wdata/data_wstrb      lane-aligned store data and byte enables
//   data_addr_ok/data_data_ok  data accept pulse / load data or store done pulse
//   data_rdata                 load word (valid with data_data_ok)
//   bus_*                      registered bus request side, handshake inputs
//   busy                       a transaction is in progress
//
// A store whose byte enables are all zero (suppressed by an exception) is
// retired locally through StLocal and never reaches the bus.
module mem_port_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  input  logic [3:0]  data_wstrb,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  output logic        bus_req,
  output logic        bus_wr,
  output logic [1:0]  bus_size,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_wstrb,
  input  logic        bus_addr_ok,
  input  logic        bus_data_ok,
  input  logic [31:0] bus_rdata,
  output logic        busy
);

  typedef enum logic [1:0] {StIdle, StAddr, StData, StLocal} state_e;

  state_e      state_q, state_d;
  logic        owner_q, owner_d;   // 0 = inst, 1 = data
  logic        last_q, last_d;     // previous winner, 0 = inst, 1 = data
  logic        wr_q, wr_d;
  logic [1:0]  size_q, size_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wstrb_q, wstrb_d;

  logic grant_inst, grant_data;
  logic in_addr, resp;

  // Round robin only matters when both request: data wins unless it won last.
  always_comb begin
    grant_data = (state_q == StIdle) && data_req && (!inst_req || !last_q);
    grant_inst = (state_q == StIdle) && inst_req && !grant_data;
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    wr_d    = wr_q;
    size_d  = size_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wstrb_d = wstrb_q;
    unique case (state_q)
      StIdle: begin
        if (grant_data) begin
          owner_d = 1'b1;
          last_d  = 1'b1;
          wr_d    = data_wr;
          size_d  = data_size;
          addr_d  = data_addr;
          wdata_d = data_wdata;
          wstrb_d = data_wstrb;
          state_d = (data_wr && (data_wstrb == 4'b0000)) ? StLocal : StAddr;
        end else if (grant_inst) begin
          owner_d = 1'b0;
          last_d  = 1'b0;
          wr_d    = 1'b0;
          size_d  = 2'd2;
          addr_d  = inst_addr;
          wdata_d = 32'h0;
          wstrb_d = 4'b0000;
          state_d = StAddr;
        end
      end
      StAddr: begin
        if (bus_addr_ok) state_d = StData;
      end
      StData: begin
        if (bus_data_ok) state_d = StIdle;
      end
      StLocal: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      owner_q <= 1'b0;
      last_q  <= 1'b0;
      wr_q    <= 1'b0;
      size_q  <= 2'd0;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      wstrb_q <= 4'b0000;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      wr_q    <= wr_d;
      size_q  <= size_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
    end
  end

  // Outputs are forced low while rst is high so an aborted transaction is
  // dropped in the reset cycle itself. The bus side depends on registers and
  // rst only, never on a request input.
  always_comb begin
    in_addr = (state_q == StAddr) && !rst;
    resp    = (state_q == StData) && bus_data_ok && !rst;

    bus_req   = in_addr;
    bus_wr    = in_addr && wr_q;
    bus_size  = in_addr ? size_q : 2'd0;
    bus_addr  = in_addr ? addr_q : 32'h0;
    bus_wdata = in_addr ? wdata_q : 32'h0;
    bus_wstrb = in_addr ? wstrb_q : 4'b0000;

    inst_addr_ok = grant_inst && !rst;
    data_addr_ok = grant_data && !rst;
    inst_data_ok = resp && !owner_q;
    data_data_ok = (resp && owner_q) || ((state_q == StLocal) && !rst);
    inst_rdata   = (resp && !owner_q) ? bus_rdata : 32'h0;
    data_rdata   = (resp && owner_q) ? bus_rdata : 32'h0;

    busy = (state_q != StIdle) && !rst;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        inst_req = 1'b0;
  logic [31:0] inst_addr = 32'h0;
  logic        inst_addr_ok, inst_data_ok;
  logic [31:0] inst_rdata;
  logic        data_req = 1'b0;
  logic        data_wr = 1'b0;
  logic [1:0]  data_size = 2'd0;
  logic [31:0] data_addr = 32'h0;
  logic [31:0] data_wdata = 32'h0;
  logic [3:0]  data_wstrb = 4'h0;
  logic        data_addr_ok, data_data_ok;
  logic [31:0] data_rdata;
  logic        bus_req, bus_wr;
  logic [1:0]  bus_size;
  logic [31:0] bus_addr, bus_wdata;
  logic [3:0]  bus_wstrb;
  logic        bus_addr_ok = 1'b0;
  logic        bus_data_ok = 1'b0;
  logic [31:0] bus_rdata = 32'h0;
  logic        busy;

  mem_port_arbiter dut (
    .clk          (clk),
    .rst          (rst),
    .inst_req     (inst_req),
    .inst_addr    (inst_addr),
    .inst_addr_ok (inst_addr_ok),
    .inst_data_ok (inst_data_ok),
    .inst_rdata   (inst_rdata),
    .data_req     (data_req),
    .data_wr      (data_wr),
    .data_size    (data_size),
    .data_addr    (data_addr),
    .data_wdata   (data_wdata),
    .data_wstrb   (data_wstrb),
    .data_addr_ok (data_addr_ok),
    .data_data_ok (data_data_ok),
    .data_rdata   (data_rdata),
    .bus_req      (bus_req),
    .bus_wr       (bus_wr),
    .bus_size     (bus_size),
    .bus_addr     (bus_addr),
    .bus_wdata    (bus_wdata),
    .bus_wstrb    (bus_wstrb),
    .bus_addr_ok  (bus_addr_ok),
    .bus_data_ok  (bus_data_ok),
    .bus_rdata    (bus_rdata),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int grants[$];  // observed grant order: 1 = data, 0 = inst

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Transaction-level reference: one pending transfer, which is either waiting
  // for its address handshake, waiting for its data, or retired locally.
  typedef struct packed {
    logic        is_data;
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } txn_t;

  initial begin
    bit   m_busy, m_local, m_in_addr, m_last_data;
    txn_t m_txn, e_bus;
    logic e_iaok, e_daok, e_idok, e_ddok, e_breq, e_busy;
    logic [31:0] e_ird, e_drd;
    m_busy = 0; m_local = 0; m_in_addr = 0; m_last_data = 0;
    m_txn = '0;
    forever begin
      @(negedge clk);
      e_iaok = 0; e_daok = 0; e_idok = 0; e_ddok = 0; e_breq = 0;
      e_ird = 32'h0; e_drd = 32'h0; e_bus = '0;
      e_busy = m_busy && !rst;
      if (!rst) begin
        if (!m_busy) begin
          e_daok = data_req && (!inst_req || !m_last_data);
          e_iaok = inst_req && !e_daok;
        end else if (m_local) begin
          e_ddok = 1;
        end else if (m_in_addr) begin
          e_breq = 1;
          e_bus  = m_txn;
        end else if (bus_data_ok) begin
          if (m_txn.is_data) begin e_ddok = 1; e_drd = bus_rdata; end
          else begin e_idok = 1; e_ird = bus_rdata; end
        end
      end
      chk("m_inst_addr_ok", 32'(inst_addr_ok), 32'(e_iaok));
      chk("m_data_addr_ok", 32'(data_addr_ok), 32'(e_daok));
      chk("m_inst_data_ok", 32'(inst_data_ok), 32'(e_idok));
      chk("m_data_data_ok", 32'(data_data_ok), 32'(e_ddok));
      chk("m_inst_rdata", inst_rdata, e_ird);
      chk("m_data_rdata", data_rdata, e_drd);
      chk("m_bus_req", 32'(bus_req), 32'(e_breq));
      chk("m_bus_wr", 32'(bus_wr), 32'(e_bus.wr));
      chk("m_bus_size", 32'(bus_size), 32'(e_bus.size));
      chk("m_bus_addr", bus_addr, e_bus.addr);
      chk("m_bus_wdata", bus_wdata, e_bus.wdata);
      chk("m_bus_wstrb", 32'(bus_wstrb), 32'(e_bus.wstrb));
      chk("m_busy", 32'(busy), 32'(e_busy));
      if (data_addr_ok) grants.push_back(1);
      if (inst_addr_ok) grants.push_back(0);
      // Advance to what holds after the coming rising edge.
      if (rst) begin
        m_busy = 0;
        m_last_data = 0;
      end else if (!m_busy) begin
        if (e_daok) begin
          m_txn = '{1'b1, data_wr, data_size, data_addr, data_wdata, data_wstrb};
          m_local = data_wr && (data_wstrb == 4'h0);
        end else if (e_iaok) begin
          m_txn = '{1'b0, 1'b0, 2'd2, inst_addr, 32'h0, 4'h0};
          m_local = 0;
        end
        if (e_daok || e_iaok) begin
          m_busy = 1;
          m_last_data = e_daok;
          m_in_addr = !m_local;
        end
      end else if (m_local) begin
        m_busy = 0;
      end else if (m_in_addr) begin
        if (bus_addr_ok) m_in_addr = 0;
      end else if (bus_data_ok) begin
        m_busy = 0;
      end
    end
  end

  // Answers the address phase after aw wait cycles, then returns rd next cycle.
  task automatic serve(input int aw, input logic [31:0] rd);
    int n = 0;
    while (!bus_req && n < 20) begin
      step();
      n++;
    end
    chk("serve_bus_req_seen", 32'(bus_req), 32'd1);
    if (!bus_req) return;
    repeat (aw) step();
    bus_addr_ok = 1;
    step();
    bus_addr_ok = 0;
    bus_data_ok = 1;
    bus_rdata   = rd;
    step();
    bus_data_ok = 0;
    bus_rdata   = 32'h0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got running, expected done");
    $fatal(1);
  end

  initial begin
    logic exp_order [3];
    exp_order = '{1'b1, 1'b0, 1'b1};

    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_bus_req", 32'(bus_req), 32'd0);
    chk("reset_inst_rdata", inst_rdata, 32'h0);
    rst = 0;
    step();

    // Fetch only, minimum latency.
    inst_req = 1; inst_addr = 32'hBFC00000;
    @(negedge clk);
    chk("fetch_addr_ok_T", 32'(inst_addr_ok), 32'd1);
    step();
    inst_req = 0; bus_addr_ok = 1;
    @(negedge clk);
    chk("fetch_bus_req_T1", 32'(bus_req), 32'd1);
    chk("fetch_bus_wr_T1", 32'(bus_wr), 32'd0);
    chk("fetch_bus_size_T1", 32'(bus_size), 32'd2);
    chk("fetch_bus_addr_T1", bus_addr, 32'hBFC00000);
    step();
    bus_addr_ok = 0; bus_data_ok = 1; bus_rdata = 32'h3C1D0000;
    @(negedge clk);
    chk("fetch_data_ok_T2", 32'(inst_data_ok), 32'd1);
    chk("fetch_rdata_T2", inst_rdata, 32'h3C1D0000);
    step();
    bus_data_ok = 0; bus_rdata = 32'h0;
    @(negedge clk);
    chk("fetch_busy_T3", 32'(busy), 32'd0);
    step();

    // Both requesting across three transactions; last grant was inst.
    grants.delete();
    inst_req = 1; inst_addr = 32'h00400000;
    data_req = 1; data_wr = 0; data_size = 2'd2; data_addr = 32'h10010000;
    for (int k = 0; k < 3; k++) serve(0, 32'h1000 + 32'(k));
    inst_req = 0; data_req = 0;
    step();
    chk("rr_grant_count", 32'(grants.size()), 32'd3);
    for (int k = 0; k < 3 && k < grants.size(); k++)
      chk($sformatf("rr_grant_%0d", k), 32'(grants[k]), 32'(exp_order[k]));

    // SB store with three address wait cycles.
    data_req = 1; data_wr = 1; data_size = 2'd0; data_addr = 32'h80001003;
    data_wdata = 32'hAB000000; data_wstrb = 4'b1000;
    @(negedge clk);
    chk("sb_addr_ok", 32'(data_addr_ok), 32'd1);
    step();
    data_req = 0;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("sb_bus_req_%0d", i), 32'(bus_req), 32'd1);
      chk($sformatf("sb_bus_addr_%0d", i), bus_addr, 32'h80001003);
      chk($sformatf("sb_bus_wdata_%0d", i), bus_wdata, 32'hAB000000);
      chk($sformatf("sb_bus_wstrb_%0d", i), 32'(bus_wstrb), 32'h8);
      chk($sformatf("sb_bus_wr_size_%0d", i), {29'h0, bus_wr, bus_size}, 32'h4);
      if (i == 3) bus_addr_ok = 1;
      step();
    end
    bus_addr_ok = 0; bus_data_ok = 1;
    @(negedge clk);
    chk("sb_data_ok", 32'(data_data_ok), 32'd1);
    step();
    bus_data_ok = 0;
    step();

    // Suppressed store: retired locally.
    data_req = 1; data_wr = 1; data_size = 2'd2; data_addr = 32'h80002000;
    data_wdata = 32'h12345678; data_wstrb = 4'b0000;
    @(negedge clk);
    chk("sup_addr_ok_T", 32'(data_addr_ok), 32'd1);
    step();
    data_req = 0;
    @(negedge clk);
    chk("sup_data_ok_T1", 32'(data_data_ok), 32'd1);
    chk("sup_bus_req_T1", 32'(bus_req), 32'd0);
    step();
    @(negedge clk);
    chk("sup_busy_T2", 32'(busy), 32'd0);
    chk("sup_data_ok_T2", 32'(data_data_ok), 32'd0);
    step();

    // Reset while waiting in DATA, then a late response.
    inst_req = 1; inst_addr = 32'h00400100;
    step();
    inst_req = 0; bus_addr_ok = 1;
    step();
    bus_addr_ok = 0;
    rst = 1;
    @(negedge clk);
    chk("rstd_busy", 32'(busy), 32'd0);
    chk("rstd_bus_req", 32'(bus_req), 32'd0);
    chk("rstd_bus_addr", bus_addr, 32'h0);
    step();
    rst = 0;
    step();
    bus_data_ok = 1; bus_rdata = 32'hDEADBEEF;
    @(negedge clk);
    chk("late_inst_data_ok", 32'(inst_data_ok), 32'd0);
    chk("late_inst_rdata", inst_rdata, 32'h0);
    chk("late_data_data_ok", 32'(data_data_ok), 32'd0);
    step();
    bus_data_ok = 0; bus_rdata = 32'h0;
    inst_req = 1; inst_addr = 32'h00400200;
    @(negedge clk);
    chk("post_rst_addr_ok", 32'(inst_addr_ok), 32'd1);
    step();
    inst_req = 0;
    serve(0, 32'h24080001);
    step();

    // Stray bus handshakes while idle.
    bus_addr_ok = 1; bus_data_ok = 1; bus_rdata = 32'hFFFFFFFF;
    @(negedge clk);
    chk("stray_busy", 32'(busy), 32'd0);
    chk("stray_inst_data_ok", 32'(inst_data_ok), 32'd0);
    chk("stray_data_data_ok", 32'(data_data_ok), 32'd0);
    step();
    bus_addr_ok = 0; bus_data_ok = 0; bus_rdata = 32'h0;
    @(negedge clk);
    chk("stray_busy_after", 32'(busy), 32'd0);
    chk("stray_bus_req_after", 32'(bus_req), 32'd0);
    step();
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
